// File: rtl/register_bank_if.sv
// Write/read bus of the register bank: one write port plus an independent
// combinational read port.
interface register_bank_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  we;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output we,
      output write_addr,
      output write_data,
      output read_addr,
      input  read_data
   );

   modport slave (
      input  we,
      input  write_addr,
      input  write_data,
      input  read_addr,
      output read_data
   );
endinterface

// File: rtl/register_bank.sv
// General-purpose register file: DEPTH x DATA_WIDTH storage with one clocked
// write port, one combinational read port and an async active-low clear.
module register_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 2**ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   register_bank_if.slave   rf_if
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   // An unknown we evaluates false here, so only a known write touches storage.
   always_comb begin
      mem_d = mem_q;
      if (rf_if.we) begin
         mem_d[rf_if.write_addr] = rf_if.write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // No write-to-read bypass: the read port only ever sees stored contents.
   assign rf_if.read_data = mem_q[rf_if.read_addr];

endmodule

// File: tb/tb_register_bank.sv
// Randomised and directed self-checking bench for register_bank against an
// array-based reference model.
`timescale 1ns/100ps
module tb_register_bank;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int N  = 8;

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic rst_n;

   register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

   register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf_if (rf_if)
   );

   initial begin
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] model [N];

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) model[i] = '0;
   endtask

   // Sweep every address; 8 x 0.5ns fits inside the low half of the clock.
   task automatic sweep(input string tag);
      for (int a = 0; a < N; a++) begin
         rf_if.read_addr = AW'(a);
         #0.5;
         chk($sformatf("%s[%0d]", tag, a), rf_if.read_data, model[a]);
      end
   endtask

   // Drive at negedge, capture at posedge, return 1ns later.
   task automatic write_cycle(input logic w, input int wa, input logic [DW-1:0] wd);
      @(negedge clk);
      rf_if.we = w;
      rf_if.write_addr = AW'(wa);
      rf_if.write_data = wd;
      @(posedge clk);
      if (w && rst_n) model[wa] = wd;
      #1;
   endtask

   initial begin
      rf_if.we = 1'b0;
      rf_if.write_addr = '0;
      rf_if.write_data = '0;
      rf_if.read_addr = '0;
      rst_n = 1'b0;
      model_clear();

      // Reset without any clock edge
      #1;
      sweep("rst_noclk");

      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sweep("rst_release");

      // Basic write/read
      write_cycle(1'b1, 3, 8'hAA);
      rf_if.we = 1'b0;
      @(negedge clk);
      sweep("basic");

      // Write-enable gating
      repeat (3) write_cycle(1'b0, 5, 8'h55);
      @(negedge clk);
      sweep("gated");
      write_cycle(1'b1, 5, 8'h55);
      rf_if.we = 1'b0;
      @(negedge clk);
      sweep("enabled");

      // Same address on both ports
      @(negedge clk);
      rf_if.read_addr = 3'd5;
      rf_if.we = 1'b1;
      rf_if.write_addr = 3'd5;
      rf_if.write_data = 8'hA3;
      #1;
      chk("same_addr_before", rf_if.read_data, 8'h55);
      @(posedge clk);
      model[5] = 8'hA3;
      #1;
      chk("same_addr_after", rf_if.read_data, 8'hA3);

      // Full sweep then overwrite register 7
      for (int i = 0; i < N; i++) write_cycle(1'b1, i, DW'(8'h10 + i));
      rf_if.we = 1'b0;
      @(negedge clk);
      sweep("full");
      write_cycle(1'b1, 7, 8'hFF);
      rf_if.we = 1'b0;
      @(negedge clk);
      sweep("over7");

      // Async reset mid-operation with a write pending; the sweep spans an edge
      @(negedge clk);
      rf_if.we = 1'b1;
      rf_if.write_addr = 3'd2;
      rf_if.write_data = 8'h77;
      #1;
      rst_n = 1'b0;
      model_clear();
      #1;
      sweep("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      write_cycle(1'b1, 2, 8'h77);
      rf_if.we = 1'b0;
      @(negedge clk);
      sweep("post_rst");

      // Unknown write enable must leave other registers intact
      for (int i = 0; i < N; i++) write_cycle(1'b1, i, DW'(8'hC0 + i));
      @(negedge clk);
      rf_if.we = 1'bx;
      rf_if.write_addr = 3'd4;
      rf_if.write_data = 8'h00;
      @(posedge clk);
      #1;
      rf_if.we = 1'b0;
      for (int a = 0; a < N; a++) begin
         if (a == 4) continue;
         rf_if.read_addr = AW'(a);
         #0.5;
         chk($sformatf("x_we[%0d]", a), rf_if.read_data, model[a]);
      end

      // Randomised traffic, including occasional reset pulses
      for (int it = 0; it < 300; it++) begin
         logic w;
         int wa, ra;
         logic [DW-1:0] wd;
         w  = 1'($urandom_range(0, 1));
         wa = int'($urandom_range(0, N-1));
         ra = int'($urandom_range(0, N-1));
         wd = DW'($urandom);
         @(negedge clk);
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            model_clear();
            #1;
            rf_if.read_addr = AW'(ra);
            #0.5;
            chk("rand_rst", rf_if.read_data, model[ra]);
            #1;
            rst_n = 1'b1;
         end
         rf_if.we = w;
         rf_if.write_addr = AW'(wa);
         rf_if.write_data = wd;
         rf_if.read_addr = AW'(ra);
         #1;
         chk("rand_pre", rf_if.read_data, model[ra]);
         @(posedge clk);
         if (w) model[wa] = wd;
         #1;
         chk("rand_post", rf_if.read_data, model[ra]);
      end
      rf_if.we = 1'b0;
      @(negedge clk);
      sweep("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/register_bank.md
# register_bank

Parameterized register file with one synchronous write port and one combinational read port. The default configuration holds eight 8-bit registers. It is the general-purpose storage element of the datapath: a producer writes through the write port, and a consumer reads any register at any time through the independent read port. An active-low asynchronous reset clears every register.

## Interface
Parameters:
- DATA_WIDTH, default 8: width of each register and of the data ports.
- ADDR_WIDTH, default 3: width of the address ports.
- DEPTH, default 2**ADDR_WIDTH (8): number of registers. It must equal 2**ADDR_WIDTH, so every address is valid.

Ports. One clock; reset is asynchronous and active-low.
- clk  input  1: system clock. All writes occur on its rising edge.
- rst_n  input  1: asynchronous, active-low reset. Clears all registers.
- we  input  1: write enable, sampled on the rising edge of clk.
- write_addr  input  ADDR_WIDTH: index of the register to write.
- write_data  input  DATA_WIDTH: value to write.
- read_addr  input  ADDR_WIDTH: index of the register to read.
- read_data  output  DATA_WIDTH: current contents of register[read_addr].

## Operation
- Storage is DEPTH registers of DATA_WIDTH bits each, indexed 0..DEPTH-1.
- **Reset:** while rst_n=0, all registers are 0, independent of clk. Consequently read_data=0 for every read_addr during reset.
- **Write:**
  - On a rising edge of clk with rst_n=1 and we=1, register[write_addr] <= write_data.
  - All other registers hold their values.
- **No write:** with we=0, no register changes, regardless of write_addr and write_data.
- **Read:**
  - read_data = register[read_addr], combinationally.
  - The read port does not depend on clk, we, write_addr or write_data, apart from the stored contents changing after a write edge.
- **No reserved register:** register 0 is writable like any other.
- **Same address on both ports:** there is no write-to-read bypass.
  - Before the edge, read_data shows the old contents.
  - After the edge, it shows write_data.
- **X on we:** with rst_n=1, the design must not corrupt registers when we is unknown. Simulation may propagate X into the addressed register only.

## Timing
- Write latency: data is visible on read_data in the same cycle, just after the rising edge that captured it, when read_addr equals write_addr.
- Read latency: zero cycles. read_data follows read_addr combinationally.
- Reset assertion takes effect immediately, without waiting for a clock.
- Reset deassertion must be synchronous to the clock at system level. The first write can occur on the first rising edge with rst_n=1.
- **Reset during a write cycle:** if rst_n falls at any point, registers are 0 and the pending write is discarded. An edge with rst_n=0 never writes.
- **Inputs held constant across edges:** with we=1 and constant inputs, the same value is rewritten each edge with no visible change.
- **Back-to-back writes:** writes on consecutive edges to different addresses each land; to the same address, the last one wins.

## Test plan
- **Reset:** assert rst_n=0 with no clock edge, then sweep read_addr 0..7 -> read_data=0x00 everywhere. Deassert reset; all registers still read 0x00.
- **Basic write/read:** we=1, write_addr=3, write_data=0xAA, one edge; then we=0, read_addr=3 -> read_data=0xAA. Other addresses still read 0x00.
- **Write-enable gating:** we=0, write_addr=5, write_data=0x55 for several edges; read_addr=5 -> 0x00. Then we=1 for one edge; read_addr=5 -> 0x55. Register 3 still reads 0xAA.
- **Simultaneous read/write, same address:** read_addr=write_addr=5, we=1, write_data=0xA3.
  - Before the edge: read_data=0x55.
  - After the edge: read_data=0xA3.
- **Full sweep:** write register i = 0x10+i for i=0..7 on consecutive edges, then read all -> each returns 0x10+i. Overwrite register 7 with 0xFF -> only register 7 changes.
- **Asynchronous reset mid-operation:** after the sweep, pulse rst_n low between clock edges while we=1 -> all registers read 0x00 immediately. The first edge after deassertion writes normally.
